// File: rtl/pipeline_pkg.sv
// Shared fetch-stage definitions: PC FSM encoding, default fetch addresses
// and the word-alignment helper used on every redirect target.
package pipeline_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } pc_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h8000_0180;
    localparam logic [31:0] ALIGN_MASK         = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_addr(input logic [31:0] addr);
        return addr & ALIGN_MASK;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pc_control.sv
// Fetch-stage PC unit: picks the next fetch address from exception, branch,
// jump and sequential sources, and parks a redirect that arrives during a stall.
module pc_control
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_hazard,
    input  logic [31:0]      branch_target,
    input  logic             jump,
    input  logic [31:0]      jump_target,
    input  logic             exception,
    output logic [31:0]      pc_out,
    output logic [31:0]      pc_plus4,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             redirect_pending,
    output logic [CNT_W-1:0] redirect_count
);

    pc_state_t   r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pending_pc;

    pc_state_t   w_next_state;
    logic [31:0] w_next_pc;
    logic [31:0] w_next_pending;
    logic [31:0] w_pc_plus4;
    logic        w_if_id_flush;
    logic        w_id_ex_flush;

    assign w_pc_plus4 = r_pc + 32'd4;

    always_comb begin
        w_next_state   = r_state;
        w_next_pc      = r_pc;
        w_next_pending = r_pending_pc;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                if (exception) begin
                    w_next_pc     = EXC_VECTOR;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (stall) begin
                    // Park the redirect; the flush happens when the stall lifts.
                    if (branch_hazard) begin
                        w_next_pending = align_addr(branch_target);
                        w_next_state   = ST_HOLD;
                    end else if (jump) begin
                        w_next_pending = align_addr(jump_target);
                        w_next_state   = ST_HOLD;
                    end
                end else if (branch_hazard) begin
                    w_next_pc     = align_addr(branch_target);
                    w_if_id_flush = 1'b1;
                end else if (jump) begin
                    w_next_pc     = align_addr(jump_target);
                    w_if_id_flush = 1'b1;
                end else begin
                    w_next_pc = w_pc_plus4;
                end
            end
            ST_HOLD: begin
                if (exception) begin
                    w_next_pc      = EXC_VECTOR;
                    w_next_pending = '0;
                    w_next_state   = ST_RUN;
                    w_if_id_flush  = 1'b1;
                    w_id_ex_flush  = 1'b1;
                end else if (!stall) begin
                    w_next_pc     = align_addr(r_pending_pc);
                    w_next_state  = ST_RUN;
                    w_if_id_flush = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_pending_pc <= '0;
        end else begin
            r_state      <= w_next_state;
            r_pc         <= w_next_pc;
            r_pending_pc <= w_next_pending;
        end
    end

    // Strobes are gated so an exception seen during reset cannot leak out.
    assign if_id_flush      = reset & w_if_id_flush;
    assign id_ex_flush      = reset & w_id_ex_flush;
    assign redirect_pending = reset & (r_state == ST_HOLD);
    assign pc_out           = r_pc;
    assign pc_plus4         = w_pc_plus4;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_redirect_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_inc   (if_id_flush),
        .o_count (redirect_count)
    );

endmodule

// File: tb/tb_pc_control.sv
// Directed self-checking bench for pc_control; each task drives one scenario
// and compares against hand-computed fetch addresses and strobes.
module tb_pc_control;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_hazard;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exception;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        redirect_pending;
    logic [15:0] redirect_count;

    int total = 0;
    int bad   = 0;

    pc_control dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .branch_hazard    (branch_hazard),
        .branch_target    (branch_target),
        .jump             (jump),
        .jump_target      (jump_target),
        .exception        (exception),
        .pc_out           (pc_out),
        .pc_plus4         (pc_plus4),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .redirect_pending (redirect_pending),
        .redirect_count   (redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        stall         = 1'b0;
        branch_hazard = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        exception     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        exception = 1'b1;
        @(negedge clk);
        total++;
        if (pc_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); end
        total++;
        if (redirect_count !== 16'h0) begin bad++; $display("[TB] FAIL reset_count got=%h exp=%h", redirect_count, 16'h0); end
        total++;
        if ({if_id_flush, id_ex_flush, redirect_pending} !== 3'b000) begin
            bad++; $display("[TB] FAIL reset_strobes got=%b exp=%b", {if_id_flush, id_ex_flush, redirect_pending}, 3'b000);
        end
        @(posedge clk);
        #1;
        total++;
        if (pc_out !== 32'h0) begin bad++; $display("[TB] FAIL reset_hold_pc got=%h exp=%h", pc_out, 32'h0); end
        exception = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (pc_out !== 32'(4 * i)) begin bad++; $display("[TB] FAIL seq_pc[%0d] got=%h exp=%h", i, pc_out, 32'(4 * i)); end
            total++;
            if ({if_id_flush, id_ex_flush} !== 2'b00) begin bad++; $display("[TB] FAIL seq_flush[%0d] got=%b exp=00", i, {if_id_flush, id_ex_flush}); end
            @(posedge clk);
            #1;
        end
        total++;
        if (redirect_count !== 16'd0) begin bad++; $display("[TB] FAIL seq_count got=%0d exp=0", redirect_count); end
    endtask

    task automatic test_branch();
        total++;
        if (pc_out !== 32'h10) begin bad++; $display("[TB] FAIL br_start got=%h exp=%h", pc_out, 32'h10); end
        branch_hazard = 1'b1;
        branch_target = 32'h40;
        @(negedge clk);
        total++;
        if ({if_id_flush, id_ex_flush} !== 2'b10) begin bad++; $display("[TB] FAIL br_flush got=%b exp=10", {if_id_flush, id_ex_flush}); end
        @(posedge clk);
        #1;
        clear_inputs();
        total++;
        if (pc_out !== 32'h40) begin bad++; $display("[TB] FAIL br_pc got=%h exp=%h", pc_out, 32'h40); end
        total++;
        if (redirect_count !== 16'd1) begin bad++; $display("[TB] FAIL br_count got=%0d exp=1", redirect_count); end
    endtask

    task automatic test_stalled_branch();
        jump        = 1'b1;
        jump_target = 32'h20;
        @(posedge clk);
        #1;
        clear_inputs();
        total++;
        if (pc_out !== 32'h20) begin bad++; $display("[TB] FAIL jmp_pc got=%h exp=%h", pc_out, 32'h20); end
        stall         = 1'b1;
        branch_hazard = 1'b1;
        branch_target = 32'h84;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (if_id_flush !== 1'b0) begin bad++; $display("[TB] FAIL stall_flush[%0d] got=%b exp=0", i, if_id_flush); end
            @(posedge clk);
            #1;
            total++;
            if (pc_out !== 32'h20) begin bad++; $display("[TB] FAIL stall_pc[%0d] got=%h exp=%h", i, pc_out, 32'h20); end
            total++;
            if (redirect_pending !== 1'b1) begin bad++; $display("[TB] FAIL stall_pending[%0d] got=%b exp=1", i, redirect_pending); end
        end
        clear_inputs();
        @(negedge clk);
        total++;
        if ({if_id_flush, id_ex_flush} !== 2'b10) begin bad++; $display("[TB] FAIL release_flush got=%b exp=10", {if_id_flush, id_ex_flush}); end
        @(posedge clk);
        #1;
        total++;
        if (pc_out !== 32'h84) begin bad++; $display("[TB] FAIL release_pc got=%h exp=%h", pc_out, 32'h84); end
        total++;
        if (redirect_pending !== 1'b0) begin bad++; $display("[TB] FAIL release_pending got=%b exp=0", redirect_pending); end
        total++;
        if (redirect_count !== 16'd3) begin bad++; $display("[TB] FAIL release_count got=%0d exp=3", redirect_count); end
        @(negedge clk);
        total++;
        if (if_id_flush !== 1'b0) begin bad++; $display("[TB] FAIL release_single_pulse got=%b exp=0", if_id_flush); end
        @(posedge clk);
        #1;
        total++;
        if (pc_out !== 32'h88) begin bad++; $display("[TB] FAIL release_next got=%h exp=%h", pc_out, 32'h88); end
    endtask

    task automatic test_exception();
        stall         = 1'b1;
        branch_hazard = 1'b1;
        branch_target = 32'h100;
        @(posedge clk);
        #1;
        total++;
        if ({redirect_pending, pc_out} !== {1'b1, 32'h88}) begin
            bad++; $display("[TB] FAIL exc_setup got=%b/%h exp=1/%h", redirect_pending, pc_out, 32'h88);
        end
        exception   = 1'b1;
        jump        = 1'b1;
        jump_target = 32'h300;
        @(negedge clk);
        total++;
        if ({if_id_flush, id_ex_flush} !== 2'b11) begin bad++; $display("[TB] FAIL exc_flush got=%b exp=11", {if_id_flush, id_ex_flush}); end
        @(posedge clk);
        #1;
        clear_inputs();
        total++;
        if (pc_out !== 32'h8000_0180) begin bad++; $display("[TB] FAIL exc_pc got=%h exp=%h", pc_out, 32'h8000_0180); end
        total++;
        if (redirect_pending !== 1'b0) begin bad++; $display("[TB] FAIL exc_pending got=%b exp=0", redirect_pending); end
        total++;
        if (redirect_count !== 16'd4) begin bad++; $display("[TB] FAIL exc_count got=%0d exp=4", redirect_count); end
        @(posedge clk);
        #1;
        total++;
        if (pc_out !== 32'h8000_0184) begin bad++; $display("[TB] FAIL exc_next got=%h exp=%h", pc_out, 32'h8000_0184); end
    endtask

    task automatic test_alignment();
        branch_hazard = 1'b1;
        branch_target = 32'h203;
        jump          = 1'b1;
        jump_target   = 32'h300;
        @(posedge clk);
        #1;
        clear_inputs();
        total++;
        if (pc_out !== 32'h200) begin bad++; $display("[TB] FAIL align_br got=%h exp=%h", pc_out, 32'h200); end
        jump        = 1'b1;
        jump_target = 32'h302;
        @(posedge clk);
        #1;
        clear_inputs();
        total++;
        if (pc_out !== 32'h300) begin bad++; $display("[TB] FAIL align_jmp got=%h exp=%h", pc_out, 32'h300); end
        total++;
        if (redirect_count !== 16'd6) begin bad++; $display("[TB] FAIL align_count got=%0d exp=6", redirect_count); end
    endtask

    task automatic test_wrap();
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        @(posedge clk);
        #1;
        clear_inputs();
        total++;
        if (pc_plus4 !== 32'h0) begin bad++; $display("[TB] FAIL wrap_plus4 got=%h exp=%h", pc_plus4, 32'h0); end
        @(posedge clk);
        #1;
        total++;
        if (pc_out !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc got=%h exp=%h", pc_out, 32'h0); end
    endtask

    task automatic test_reset_mid_hold();
        stall         = 1'b1;
        branch_hazard = 1'b1;
        branch_target = 32'h500;
        @(posedge clk);
        #1;
        total++;
        if (redirect_pending !== 1'b1) begin bad++; $display("[TB] FAIL rmh_setup got=%b exp=1", redirect_pending); end
        clear_inputs();
        #1;
        reset = 1'b0;
        #1;
        total++;
        if ({redirect_pending, pc_out, redirect_count} !== {1'b0, 32'h0, 16'h0}) begin
            bad++; $display("[TB] FAIL rmh_async got=%b/%h/%h exp=0/0/0", redirect_pending, pc_out, redirect_count);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (pc_out !== 32'h4) begin bad++; $display("[TB] FAIL rmh_restart got=%h exp=%h", pc_out, 32'h4); end
    endtask

    task automatic test_saturation();
        branch_hazard = 1'b1;
        branch_target = 32'h40;
        for (int i = 0; i < 65534; i++) begin
            @(posedge clk);
        end
        #1;
        total++;
        if (redirect_count !== 16'hFFFE) begin bad++; $display("[TB] FAIL sat_pre got=%h exp=%h", redirect_count, 16'hFFFE); end
        @(posedge clk);
        #1;
        total++;
        if (redirect_count !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_max got=%h exp=%h", redirect_count, 16'hFFFF); end
        @(posedge clk);
        #1;
        total++;
        if (redirect_count !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_hold got=%h exp=%h", redirect_count, 16'hFFFF); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_stalled_branch();
        test_exception();
        test_alignment();
        test_wrap();
        test_reset_mid_hold();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
